// File: rtl/input_line_filter.sv
// input_line_filter: per-line synchronizer and glitch filter with rise/fall
// pulses and a first-word-fall-through FIFO of timestamped change events.
module input_line_filter #(
  parameter int               WIDTH         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               FILTER_CYCLES = 3,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = {WIDTH{1'b1}},
  parameter int               TS_WIDTH      = 16,
  parameter int               FIFO_DEPTH    = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [WIDTH-1:0]    in_line,
  output logic [WIDTH-1:0]    out_line,
  output logic [WIDTH-1:0]    rise_pulse,
  output logic [WIDTH-1:0]    fall_pulse,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [WIDTH-1:0]    evt_lines,
  output logic [TS_WIDTH-1:0] evt_time,
  output logic                overflow,
  input  logic                clear_overflow
);

  // Counter only needs to reach FILTER_CYCLES-1.
  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0]    r_sync [SYNC_STAGES];
  logic [CW-1:0]       r_cnt  [WIDTH];
  logic [WIDTH-1:0]    r_out;
  logic [WIDTH-1:0]    r_rise;
  logic [WIDTH-1:0]    r_fall;
  logic [TS_WIDTH-1:0] r_ts;
  logic [WIDTH-1:0]    r_mem_lines [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] r_mem_time  [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_fcnt;
  logic                r_ovf;

  logic [WIDTH-1:0]    w_synced;
  logic [WIDTH-1:0]    w_accept;
  logic                w_push;
  logic                w_full;
  logic                w_pop;
  logic                w_wr;
  logic                w_drop;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Per-bit acceptance: new level has persisted for the full filter window.
  always_comb begin
    w_accept = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if ((w_synced[b] != r_out[b]) && (r_cnt[b] == CNT_MAX)) begin
        w_accept[b] = 1'b1;
      end else begin
        w_accept[b] = 1'b0;
      end
    end
  end

  // An event is pushed in the cycle after the pulses; a pop frees room for it.
  assign w_push = |(r_rise | r_fall);
  assign w_full = (r_fcnt == (AW + 1)'(FIFO_DEPTH));
  assign w_pop  = (r_fcnt != '0) && evt_ready;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  // Synchronizer flop chain per bit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= RESET_LEVEL;
    end else begin
      r_sync[0] <= in_line;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Glitch filter counters, filtered level and registered edge pulses.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int b = 0; b < WIDTH; b++) r_cnt[b] <= '0;
      r_out  <= RESET_LEVEL;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if ((w_synced[b] == r_out[b]) || w_accept[b]) begin
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CW'(1);
        end
      end
      r_out  <= r_out ^ w_accept;
      r_rise <= w_accept & w_synced;
      r_fall <= w_accept & ~w_synced;
    end
  end

  // Free-running timestamp, wraps silently.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // Event storage; contents are only visible while the entry is occupied.
  always_ff @(posedge sys_clk) begin
    if (w_wr) begin
      r_mem_lines[r_wr_ptr] <= r_out;
      r_mem_time[r_wr_ptr]  <= r_ts;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_fcnt <= r_fcnt + (AW + 1)'(1);
        2'b01:   r_fcnt <= r_fcnt - (AW + 1)'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clear_overflow) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign out_line   = r_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign evt_valid  = (r_fcnt != '0);
  assign evt_lines  = evt_valid ? r_mem_lines[r_rd_ptr] : '0;
  assign evt_time   = evt_valid ? r_mem_time[r_rd_ptr]  : '0;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_input_line_filter.sv
// Self-checking bench for input_line_filter: directed scenarios plus random
// traffic compared against a history/window based reference model.
module tb_input_line_filter;

  localparam int W   = 4;
  localparam int SS  = 2;
  localparam int FC  = 3;
  localparam int TSW = 16;
  localparam int FD  = 4;
  localparam logic [W-1:0] RL = 4'hF;

  typedef struct {
    logic [W-1:0]   l;
    logic [TSW-1:0] t;
  } ev_t;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic [W-1:0]   in_line;
  logic [W-1:0]   out_line, rise_pulse, fall_pulse, evt_lines;
  logic           evt_valid, evt_ready, overflow, clear_overflow;
  logic [TSW-1:0] evt_time;

  input_line_filter #(
    .WIDTH(W), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .RESET_LEVEL(RL),
    .TS_WIDTH(TSW), .FIFO_DEPTH(FD)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_line(in_line),
    .out_line(out_line), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_lines(evt_lines),
    .evt_time(evt_time), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  int           m_e;
  logic [W-1:0] cap_hist[$];
  logic [W-1:0] s_hist[$];
  logic [W-1:0] m_out, m_rise, m_fall;
  logic         m_ovf, m_pend;
  ev_t          m_pend_ev;
  ev_t          m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_e = 0;
    cap_hist.delete();
    s_hist.delete();
    m_q.delete();
    m_out  = RL;
    m_rise = '0;
    m_fall = '0;
    m_ovf  = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic compare();
    chk("out_line", 32'(out_line), 32'(m_out));
    chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    chk("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      chk("evt_lines", 32'(evt_lines), 32'(m_q[0].l));
      chk("evt_time", 32'(evt_time), 32'(m_q[0].t));
    end
  endtask

  // One clock edge: advance the model from pre-edge inputs, then check.
  task automatic step();
    logic [W-1:0] s_now, nw;
    logic pop, full, drop, all_diff;
    ev_t tmp;
    @(posedge sys_clk);
    if (sys_rst) begin
      reset_model();
    end else begin
      m_e++;
      pop  = (m_q.size() != 0) && evt_ready;
      full = (m_q.size() == FD);
      drop = m_pend && full && !pop;
      if (pop) tmp = m_q.pop_front();
      if (m_pend && !drop) m_q.push_back(m_pend_ev);
      if (drop) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      // value the filter sees at this edge: input captured SS edges earlier
      s_now = (m_e - SS >= 1) ? cap_hist[m_e - SS - 1] : RL;
      s_hist.push_back(s_now);
      cap_hist.push_back(in_line);
      nw = m_out;
      for (int b = 0; b < W; b++) begin
        if (m_e >= FC) begin
          all_diff = 1'b1;
          for (int k = m_e - FC + 1; k <= m_e; k++)
            if (s_hist[k-1][b] == m_out[b]) all_diff = 1'b0;
          if (all_diff) nw[b] = ~m_out[b];
        end
      end
      m_rise = nw & ~m_out;
      m_fall = ~nw & m_out;
      m_out  = nw;
      m_pend = |(m_rise | m_fall);
      m_pend_ev.l = m_out;
      m_pend_ev.t = TSW'(m_e);
    end
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic seen;
    sys_rst = 1'b1;
    in_line = 4'hF;
    evt_ready = 1'b0;
    clear_overflow = 1'b0;
    reset_model();
    #2;
    compare();
    chk("reset_evt_lines", 32'(evt_lines), 32'h0);
    chk("reset_evt_time", 32'(evt_time), 32'h0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    // Idle at F long enough for the timestamp to wrap, then one falling edge
    evt_ready = 1'b1;
    steps(65540);
    in_line = 4'hE;
    steps(10);
    in_line = 4'hF;
    steps(10);

    // Glitches of 1, 2, 3 cycles on bit 1
    in_line = 4'hD; steps(1); in_line = 4'hF; steps(8);
    in_line = 4'hD; steps(2); in_line = 4'hF; steps(8);
    in_line = 4'hD; steps(3); in_line = 4'hF; steps(10);

    // All bits fall together, then rise together
    in_line = 4'h0; steps(10);
    in_line = 4'hF; steps(10);

    // Five changes with consumer stalled: fill FIFO, drop the fifth
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_line[2] = ~in_line[2];
      steps(8);
    end
    steps(5);
    clear_overflow = 1'b1; steps(1); clear_overflow = 1'b0;
    steps(3);

    // FIFO full: push and pop in the same cycle keeps the new event
    in_line[3] = ~in_line[3];
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = |(m_rise | m_fall);
    end
    chk("pulse_seen", 32'(seen), 32'h1);
    evt_ready = 1'b1; steps(1); evt_ready = 1'b0;
    steps(4);
    evt_ready = 1'b1; steps(8);

    // Reset mid-stream with queued events and a filter count in progress
    evt_ready = 1'b0;
    in_line = 4'hF; steps(8);
    for (int i = 0; i < 3; i++) begin
      in_line[0] = ~in_line[0];
      steps(8);
    end
    in_line[1] = 1'b0;
    steps(3);
    sys_rst = 1'b1;
    reset_model();
    #1;
    compare();
    chk("rst_evt_valid", 32'(evt_valid), 32'h0);
    chk("rst_out_line", 32'(out_line), 32'(RL));
    in_line = 4'hF;
    steps(2);
    sys_rst = 1'b0;
    steps(12);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) in_line[b] = ~in_line[b];
      evt_ready = ($urandom_range(0, 2) != 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
